care_actions: RTL and testbench

- Counterpart to the stat-decay logic, which raises needs over time. This block lowers needs when the player performs care actions.
- Turns button presses on the 8-bit `inputs` bus into decrement requests: one stat per request, with a saturating amount.
- Requests go to the stat-owning block over a valid/ready handshake.
- A cooldown follows each accepted action. Presses during the cooldown are ignored.

---
 rtl/care_actions.sv | 150 +++++++++++++++
 tb/tb_care_actions.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/care_actions.sv
// Care-action request generator: turns button rising edges into saturating
// stat-decrement requests over a valid/ready handshake, followed by a cooldown.
module care_actions #(
    parameter int COOLDOWN   = 1000,
    parameter int DEC_AMOUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] inputs,
    input  logic [3:0] hunger,
    input  logic [3:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic [3:0] social,
    input  logic       dec_ready,
    output logic       dec_valid,
    output logic [2:0] dec_sel,
    output logic [3:0] dec_amount,
    output logic       busy,
    output logic       reject,
    output logic       action_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    localparam logic [26:0] CD_LAST = 27'(COOLDOWN - 1);
    localparam logic [3:0]  DEC_AMT = 4'(DEC_AMOUNT);

    state_t      state_r, next_state_s;
    logic [7:0]  prev_r;
    logic [26:0] cnt_r, next_cnt_s;
    logic [5:0]  rise_s;
    logic [2:0]  win_idx_s;
    logic [3:0]  win_stat_s;
    logic [3:0]  win_amt_s;
    logic        next_valid_s;
    logic [2:0]  next_sel_s;
    logic [3:0]  next_amt_s;
    logic        next_reject_s;
    logic        next_done_s;
    logic        unused_bits_s;

    // Bits 6-7 are tracked for edge history but never act.
    assign unused_bits_s = ^prev_r[7:6];
    assign rise_s        = inputs[5:0] & ~prev_r[5:0];

    // Lowest-index rising button wins; stat lookup and saturating amount.
    always_comb begin
        win_idx_s  = 3'd0;
        win_stat_s = 4'd0;
        casez (rise_s)
            6'b?????1: win_idx_s = 3'd0;
            6'b????10: win_idx_s = 3'd1;
            6'b???100: win_idx_s = 3'd2;
            6'b??1000: win_idx_s = 3'd3;
            6'b?10000: win_idx_s = 3'd4;
            6'b100000: win_idx_s = 3'd5;
            default:   win_idx_s = 3'd0;
        endcase
        case (win_idx_s)
            3'd0:    win_stat_s = hunger;
            3'd1:    win_stat_s = happiness;
            3'd2:    win_stat_s = health;
            3'd3:    win_stat_s = hygiene;
            3'd4:    win_stat_s = energy;
            3'd5:    win_stat_s = social;
            default: win_stat_s = 4'd0;
        endcase
        win_amt_s = (win_stat_s < DEC_AMT) ? win_stat_s : DEC_AMT;
    end

    // Next-state and next-output logic.
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_r;
        next_valid_s  = dec_valid;
        next_sel_s    = dec_sel;
        next_amt_s    = dec_amount;
        next_reject_s = 1'b0;
        next_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s != 6'd0) begin
                    if (win_stat_s == 4'd0) begin
                        next_reject_s = 1'b1;
                    end else begin
                        next_sel_s   = win_idx_s;
                        next_amt_s   = win_amt_s;
                        next_valid_s = 1'b1;
                        next_state_s = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dec_valid && dec_ready) begin
                    next_valid_s = 1'b0;
                    next_done_s  = 1'b1;
                    next_cnt_s   = 27'd0;
                    next_state_s = ST_COOL;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_COOL: begin
                if (cnt_r == CD_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_cnt_s = cnt_r + 27'd1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_valid_s = 1'b0;
            end
        endcase
    end

    // State, edge history, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            prev_r      <= 8'hFF;
            cnt_r       <= 27'd0;
            dec_valid   <= 1'b0;
            dec_sel     <= 3'd0;
            dec_amount  <= 4'd0;
            reject      <= 1'b0;
            action_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            prev_r      <= inputs;
            cnt_r       <= next_cnt_s;
            dec_valid   <= next_valid_s;
            dec_sel     <= next_sel_s;
            dec_amount  <= next_amt_s;
            reject      <= next_reject_s;
            action_done <= next_done_s;
            busy        <= (next_state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_care_actions.sv
// Directed bench: a vector table on a short-cooldown instance plus hand
// sequences on a default-cooldown instance for handshake, cooldown and reset.
module tb_care_actions;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_a, in_b;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;
    logic       rdy;

    logic       a_valid, a_busy, a_rej, a_done;
    logic [2:0] a_sel;
    logic [3:0] a_amt;
    logic       b_valid, b_busy, b_rej, b_done;
    logic [2:0] b_sel;
    logic [3:0] b_amt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    care_actions dut (
        .clk(clk), .reset(reset), .inputs(in_a),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .dec_ready(rdy), .dec_valid(a_valid), .dec_sel(a_sel),
        .dec_amount(a_amt), .busy(a_busy), .reject(a_rej), .action_done(a_done)
    );

    care_actions #(.COOLDOWN(4), .DEC_AMOUNT(3)) dut4 (
        .clk(clk), .reset(reset), .inputs(in_b),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .dec_ready(rdy), .dec_valid(b_valid), .dec_sel(b_sel),
        .dec_amount(b_amt), .busy(b_busy), .reject(b_rej), .action_done(b_done)
    );

    typedef struct {
        logic [7:0] in;
        logic       rdy;
        logic       ev;
        logic [2:0] es;
        logic [3:0] ea;
        logic       eb;
        logic       erj;
        logic       ead;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] i, input logic r, input logic ev,
                                input logic [2:0] es, input logic [3:0] ea,
                                input logic eb, input logic erj, input logic ead);
        vec_t v;
        v.in = i; v.rdy = r; v.ev = ev; v.es = es; v.ea = ea;
        v.eb = eb; v.erj = erj; v.ead = ead;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step_a();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;
    int guard;

    initial begin
        reset = 1'b1; in_a = 8'h00; in_b = 8'h01; rdy = 1'b0;
        hunger = 4'd9; happiness = 4'd2; health = 4'd10;
        hygiene = 4'd10; energy = 4'd10; social = 4'd0;

        //         in     rdy   ev    sel   amt   busy  rej   done
        vecs.push_back(mk(8'h01, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // held through reset
        vecs.push_back(mk(8'h01, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 1'b0, 1'b1, 3'd0, 4'd3, 1'b1, 1'b0, 1'b0)); // feed
        vecs.push_back(mk(8'h00, 1'b0, 1'b1, 3'd0, 4'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1)); // handshake
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h08, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0)); // clean in cooldown
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // busy falls
        vecs.push_back(mk(8'h08, 1'b0, 1'b1, 3'd3, 4'd3, 1'b1, 1'b0, 1'b0)); // clean accepted
        vecs.push_back(mk(8'h00, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(8'hC0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // bits 6-7
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(8'h20, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0)); // pet, social 0
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(8'h1C, 1'b0, 1'b1, 3'd2, 4'd3, 1'b1, 1'b0, 1'b0)); // priority
        vecs.push_back(mk(8'h1C, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h02, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // rise on leaving edge
        vecs.push_back(mk(8'h02, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(8'hC0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // ready while idle
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        chk("rst_b_valid", 16'(b_valid), 16'd0);
        chk("rst_b_sel",   16'(b_sel),   16'd0);
        chk("rst_b_amt",   16'(b_amt),   16'd0);
        chk("rst_b_busy",  16'(b_busy),  16'd0);
        chk("rst_b_rej",   16'(b_rej),   16'd0);
        chk("rst_b_done",  16'(b_done),  16'd0);
        chk("rst_a_valid", 16'(a_valid), 16'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            in_b = vecs[i].in;
            rdy  = vecs[i].rdy;
            step_a();
            chk($sformatf("v%0d_valid", i), 16'(b_valid), 16'(vecs[i].ev));
            chk($sformatf("v%0d_busy", i),  16'(b_busy),  16'(vecs[i].eb));
            chk($sformatf("v%0d_rej", i),   16'(b_rej),   16'(vecs[i].erj));
            chk($sformatf("v%0d_done", i),  16'(b_done),  16'(vecs[i].ead));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_sel", i), 16'(b_sel), 16'(vecs[i].es));
                chk($sformatf("v%0d_amt", i), 16'(b_amt), 16'(vecs[i].ea));
            end
            @(negedge clk);
        end
        in_b = 8'h00;
        rdy  = 1'b0;

        // Play with happiness 2: amount clamps to 2, held through a stalled handshake.
        in_a = 8'h02;
        step_a();
        chk("t2_valid", 16'(a_valid), 16'd1);
        chk("t2_sel",   16'(a_sel),   16'd1);
        chk("t2_amt",   16'(a_amt),   16'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_a = 8'h00;
            step_a();
            chk($sformatf("t2_hold%0d_valid", k), 16'(a_valid), 16'd1);
            chk($sformatf("t2_hold%0d_sel", k),   16'(a_sel),   16'd1);
            chk($sformatf("t2_hold%0d_amt", k),   16'(a_amt),   16'd2);
        end
        @(negedge clk);
        rdy = 1'b1;
        step_a();
        chk("t2_hs_done",  16'(a_done),  16'd1);
        chk("t2_hs_valid", 16'(a_valid), 16'd0);
        chk("t2_hs_busy",  16'(a_busy),  16'd1);
        @(negedge clk);
        rdy = 1'b0;
        step_a();
        chk("t2_done_pulse", 16'(a_done), 16'd0);
        busy_cnt = 1;
        if (a_busy) busy_cnt++;
        guard = 0;
        while (a_busy && guard < 1100) begin
            @(negedge clk);
            step_a();
            guard++;
            if (a_busy) busy_cnt++;
        end
        chk("t2_busy_len", 16'(busy_cnt), 16'd1000);

        // Reset in the middle of a pending request.
        @(negedge clk);
        in_a = 8'h01;
        step_a();
        chk("t6_valid", 16'(a_valid), 16'd1);
        chk("t6_sel",   16'(a_sel),   16'd0);
        chk("t6_amt",   16'(a_amt),   16'd3);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_valid", 16'(a_valid), 16'd0);
        chk("t6_async_busy",  16'(a_busy),  16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step_a();
        chk("t6_held_valid", 16'(a_valid), 16'd0);
        @(negedge clk);
        in_a = 8'h00;
        step_a();
        chk("t6_drop_valid", 16'(a_valid), 16'd0);
        @(negedge clk);
        in_a = 8'h01;
        step_a();
        chk("t6_re_valid", 16'(a_valid), 16'd1);
        chk("t6_re_sel",   16'(a_sel),   16'd0);
        chk("t6_re_amt",   16'(a_amt),   16'd3);
        chk("t6_re_busy",  16'(a_busy),  16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
